// File: rtl/io_periph_pkg.sv
// io_periph_pkg: shared offsets, bus request type and byte-merge helper for io_periph_bank
package io_periph_pkg;
  localparam logic [11:0] OFF_LEDR   = 12'h000;
  localparam logic [11:0] OFF_LEDG   = 12'h010;
  localparam logic [11:0] OFF_HEX0   = 12'h020;
  localparam logic [11:0] OFF_LCD    = 12'h040;
  localparam logic [11:0] OFF_SW     = 12'h080;
  localparam logic [11:0] OFF_SWEVT  = 12'h084;
  localparam logic [11:0] OFF_IRQMSK = 12'h088;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } io_bus_req_t;
  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] be);
    apply_be = old;
    for (int i = 0; i < 4; i++) if (be[i]) apply_be[8*i+:8] = wdata[8*i+:8];
  endfunction
endpackage

// File: rtl/io_periph_bank_sw_debounce.sv
// sw_debounce: two-flop synchroniser plus stability-count debouncer
//   clk, rst_n : clock, synchronous active-low reset
//   sw         : raw asynchronous switches
//   sw_db      : debounced value
//   chg        : bits that flip in sw_db at this edge (combinational, one cycle)
module sw_debounce #(
  parameter int W = 32,
  parameter int DEBOUNCE_CYC = 16
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  output logic [W-1:0] sw_db,
  output logic [W-1:0] chg
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);
  logic [W-1:0] s1, s2, prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic load;
  // counter saturates at LAST, so a settled input keeps reloading the same value
  assign cnt_nxt = s2 != prev ? '0 : cnt == LAST ? cnt : cnt + CNT_W'(1);
  assign load = cnt_nxt == LAST;
  assign chg = load ? s2 ^ sw_db : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      cnt <= '0;
      sw_db <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      prev <= s2;
      cnt <= cnt_nxt;
      if (load) sw_db <= s2;
    end
  end
endmodule

// File: rtl/io_periph_bank.sv
// io_periph_bank: memory-mapped LED/HEX/LCD/switch register bank with switch-change interrupt
//   clk_i, rst_ni                         : clock, synchronous active-low reset
//   req_i, we_i, addr_i, wdata_i, be_i    : single-cycle request
//   rdata_o, rvalid_o, err_o              : response one cycle later
//   io_sw_i                               : raw switches
//   io_ledr_o, io_ledg_o, io_hex_o, io_lcd_o : output registers
//   irq_o                                 : |(SW_EVT & IRQ_MASK), registered
module io_periph_bank
  import io_periph_pkg::*;
#(
  parameter int N_HEX = 8,
  parameter int SW_W = 32,
  parameter int DEBOUNCE_CYC = 16
)(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [11:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  input  logic [SW_W-1:0]       io_sw_i,
  output logic [31:0]           io_ledr_o,
  output logic [31:0]           io_ledg_o,
  output logic [N_HEX*32-1:0]   io_hex_o,
  output logic [31:0]           io_lcd_o,
  output logic                  irq_o
);
  io_bus_req_t bus;
  logic [SW_W-1:0] sw_db, sw_chg, evt, mask, evt_clr;
  logic [N_HEX-1:0][31:0] hex;
  logic [31:0] hex_rd, rd_mux, mask_w, clr_w;
  logic hex_hit, mapped, err, wr;
  assign bus = '{req: req_i, we: we_i, addr: addr_i, wdata: wdata_i, be: be_i};
  assign io_hex_o = hex;
  assign hex_hit = bus.addr[11:5] == OFF_HEX0[11:5] && {29'd0, bus.addr[4:2]} < 32'(N_HEX);
  assign mapped = bus.addr inside {OFF_LEDR, OFF_LEDG, OFF_LCD, OFF_SW, OFF_SWEVT, OFF_IRQMSK} || hex_hit;
  assign err = bus.addr[1:0] != 2'b00 || !mapped || (bus.we && bus.addr == OFF_SW);
  assign wr = bus.req && bus.we && !err;
  assign mask_w = apply_be(32'(mask), bus.wdata, bus.be);
  assign clr_w = apply_be(32'd0, bus.wdata, bus.be);
  assign evt_clr = wr && bus.addr == OFF_SWEVT ? clr_w[SW_W-1:0] : '0;
  always_comb begin
    hex_rd = 32'd0;
    for (int i = 0; i < N_HEX; i++) if (bus.addr[4:2] == 3'(i)) hex_rd = hex[i];
  end
  assign rd_mux = bus.addr == OFF_LEDR ? io_ledr_o :
                  bus.addr == OFF_LEDG ? io_ledg_o :
                  bus.addr == OFF_LCD ? io_lcd_o :
                  bus.addr == OFF_SW ? 32'(sw_db) :
                  bus.addr == OFF_SWEVT ? 32'(evt) :
                  bus.addr == OFF_IRQMSK ? 32'(mask) : hex_rd;
  sw_debounce #(.W(SW_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .clk(clk_i), .rst_n(rst_ni), .sw(io_sw_i), .sw_db(sw_db), .chg(sw_chg)
  );
  // responses return the pre-edge register value for every successful access
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
      rvalid_o <= 1'b0;
      err_o <= 1'b0;
      irq_o <= 1'b0;
      io_ledr_o <= '0;
      io_ledg_o <= '0;
      io_lcd_o <= '0;
      hex <= '0;
      evt <= '0;
      mask <= '0;
    end else begin
      rvalid_o <= bus.req;
      err_o <= bus.req && err;
      rdata_o <= bus.req && !err ? rd_mux : 32'd0;
      irq_o <= |(evt & mask);
      evt <= (evt & ~evt_clr) | sw_chg;
      if (wr && bus.addr == OFF_LEDR) io_ledr_o <= apply_be(io_ledr_o, bus.wdata, bus.be);
      if (wr && bus.addr == OFF_LEDG) io_ledg_o <= apply_be(io_ledg_o, bus.wdata, bus.be);
      if (wr && bus.addr == OFF_LCD) io_lcd_o <= apply_be(io_lcd_o, bus.wdata, bus.be);
      if (wr && bus.addr == OFF_IRQMSK) mask <= mask_w[SW_W-1:0];
      for (int i = 0; i < N_HEX; i++)
        if (wr && hex_hit && bus.addr[4:2] == 3'(i)) hex[i] <= apply_be(hex[i], bus.wdata, bus.be);
    end
  end
endmodule
